fcvt_arb_ctrl: RTL and testbench

FCVT_ARB_CTRL -- requirements
Module: fcvt_arb_ctrl

---
 rtl/fcvt_arb_ctrl.sv | 112 +++++++++++
 tb/tb_fcvt_arb_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fcvt_arb_ctrl.sv
// Two-requester round-robin front end for a shared combinational float-to-int converter.
// Latency: grant edge -> EXEC -> RESP (3 cycles/op); resp holds until resp_ready, no grants meanwhile.
module fcvt_arb_ctrl #(
  parameter int BUS_WIDTH = 64,
  parameter int TAG_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [BUS_WIDTH-1:0] req0_data,
  input  logic [TAG_W-1:0]     req0_tag,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [BUS_WIDTH-1:0] req1_data,
  input  logic [TAG_W-1:0]     req1_tag,
  output logic [BUS_WIDTH-1:0] cvt_in,
  input  logic [BUS_WIDTH-1:0] cvt_out,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [BUS_WIDTH-1:0] resp_data,
  output logic                 resp_id,
  output logic [TAG_W-1:0]     resp_tag,
  output logic                 resp_nv
);

  localparam int MANT = (BUS_WIDTH == 64) ? 52 : 23;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic                 id;
    logic [TAG_W-1:0]     tag;
    logic [BUS_WIDTH-1:0] data;
  } op_t;

  state_t state, state_nxt;
  op_t    op_q, op_sel;
  logic   last_grant;
  logic   grant_any;
  logic   grant_sel;
  logic   accept;

  // Contention goes to the requester not served last; a lone requester always wins.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_sel = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    op_sel.id   = grant_sel;
    op_sel.tag  = grant_sel ? req1_tag  : req0_tag;
    op_sel.data = grant_sel ? req1_data : req0_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // rst gates ready so no grant is visible while reset is still asserted.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any && !rst) begin
          accept     = 1'b1;
          req0_ready = ~grant_sel;
          req1_ready = grant_sel;
          state_nxt  = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      op_q       <= '0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
      resp_tag   <= '0;
      resp_nv    <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= grant_sel;
        op_q       <= op_sel;
      end
      // Exponent all ones marks NaN or infinity regardless of the converter's saturation value.
      if (state == EXEC) begin
        resp_data <= cvt_out;
        resp_nv   <= &op_q.data[BUS_WIDTH-2:MANT];
        resp_id   <= op_q.id;
        resp_tag  <= op_q.tag;
      end
    end
  end

  assign cvt_in     = op_q.data;
  assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_fcvt_arb_ctrl.sv
// Directed bench for fcvt_arb_ctrl: 64-bit instance with arbitration/backpressure/reset steps,
// plus a 32-bit instance for single-precision conversion.
module tb_fcvt_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        r0v, r1v, rr;
  logic [63:0] r0d, r1d;
  logic [3:0]  r0t, r1t;
  logic        req0_ready, req1_ready;
  logic [63:0] cvt_in, cvt_out, resp_data;
  logic        resp_valid, resp_id, resp_nv;
  logic [3:0]  resp_tag;

  logic        s_r0v, s_r1v, s_rr;
  logic [31:0] s_r0d, s_r1d;
  logic [3:0]  s_r0t, s_r1t;
  logic        s_req0_ready, s_req1_ready;
  logic [31:0] s_cvt_in, s_cvt_out, s_resp_data;
  logic        s_resp_valid, s_resp_id, s_resp_nv;
  logic [3:0]  s_resp_tag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] f2i64(input logic [63:0] x);
    real r, t;
    if (&x[62:52]) return (x[63] && x[51:0] == 52'd0) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    r = $bitstoreal(x);
    t = (r < 0.0) ? -$floor(-r) : $floor(r);
    if (t >= 9.223372036854775807e18) return 64'h7FFF_FFFF_FFFF_FFFF;
    if (t < -9.223372036854775808e18) return 64'h8000_0000_0000_0000;
    return 64'(longint'(t));
  endfunction

  function automatic logic [31:0] f2i32(input logic [31:0] x);
    logic [63:0] d;
    real         r, t;
    longint      v;
    if (&x[30:23]) return (x[31] && x[22:0] == 23'd0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (x[30:23] == 8'd0) return 32'd0;
    d = {x[31], 11'({3'b000, x[30:23]} + 11'd896), x[22:0], 29'd0};
    r = $bitstoreal(d);
    t = (r < 0.0) ? -$floor(-r) : $floor(r);
    if (t >= 2147483647.0) return 32'h7FFF_FFFF;
    if (t <= -2147483648.0) return 32'h8000_0000;
    v = longint'(t);
    return v[31:0];
  endfunction

  assign cvt_out   = f2i64(cvt_in);
  assign s_cvt_out = f2i32(s_cvt_in);

  fcvt_arb_ctrl #(.BUS_WIDTH(64), .TAG_W(4)) u_dut64 (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(req0_ready), .req0_data(r0d), .req0_tag(r0t),
    .req1_valid(r1v), .req1_ready(req1_ready), .req1_data(r1d), .req1_tag(r1t),
    .cvt_in(cvt_in), .cvt_out(cvt_out),
    .resp_valid(resp_valid), .resp_ready(rr), .resp_data(resp_data),
    .resp_id(resp_id), .resp_tag(resp_tag), .resp_nv(resp_nv)
  );

  fcvt_arb_ctrl #(.BUS_WIDTH(32), .TAG_W(4)) u_dut32 (
    .clk(clk), .rst(rst),
    .req0_valid(s_r0v), .req0_ready(s_req0_ready), .req0_data(s_r0d), .req0_tag(s_r0t),
    .req1_valid(s_r1v), .req1_ready(s_req1_ready), .req1_data(s_r1d), .req1_tag(s_r1t),
    .cvt_in(s_cvt_in), .cvt_out(s_cvt_out),
    .resp_valid(s_resp_valid), .resp_ready(s_rr), .resp_data(s_resp_data),
    .resp_id(s_resp_id), .resp_tag(s_resp_tag), .resp_nv(s_resp_nv)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle with the request already driven; ends one cycle after the
  // response handshake (resp_ready assumed high), back in IDLE.
  task automatic run_txn(input logic id, input logic [3:0] tag, input logic [63:0] op,
                         input logic [63:0] data, input logic nv);
    #1;
    check("grant0", {63'd0, req0_ready}, {63'd0, ~id});
    check("grant1", {63'd0, req1_ready}, {63'd0, id});
    check("idle_vld", {63'd0, resp_valid}, 64'd0);
    step;
    check("exec_rdy", {63'd0, req0_ready | req1_ready}, 64'd0);
    check("exec_vld", {63'd0, resp_valid}, 64'd0);
    check("exec_cvt_in", cvt_in, op);
    step;
    check("resp_vld", {63'd0, resp_valid}, 64'd1);
    check("resp_data", resp_data, data);
    check("resp_id", {63'd0, resp_id}, {63'd0, id});
    check("resp_tag", {60'd0, resp_tag}, {60'd0, tag});
    check("resp_nv", {63'd0, resp_nv}, {63'd0, nv});
    step;
    check("post_vld", {63'd0, resp_valid}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    r0v = 1'b0; r1v = 1'b0; rr = 1'b1;
    r0d = '0; r1d = '0; r0t = '0; r1t = '0;
    s_r0v = 1'b0; s_r1v = 1'b0; s_rr = 1'b1;
    s_r0d = '0; s_r1d = '0; s_r0t = '0; s_r1t = '0;

    // Reset state, including no ready while rst is held with a request pending
    #2;
    check("rst_vld", {63'd0, resp_valid}, 64'd0);
    check("rst_cvt_in", cvt_in, 64'd0);
    check("rst_data", resp_data, 64'd0);
    r0v = 1'b1; r0d = 64'h4024_0000_0000_0000; r0t = 4'd3;
    #1;
    check("rst_rdy0", {63'd0, req0_ready}, 64'd0);
    step; step;
    check("rst_rdy0_held", {63'd0, req0_ready}, 64'd0);
    check("rst_cvt_in_held", cvt_in, 64'd0);

    // 10.0 from req0 alone
    rst = 1'b0;
    run_txn(1'b0, 4'd3, 64'h4024_0000_0000_0000, 64'd10, 1'b0);
    r0v = 1'b0;

    // Fresh reset, then both requesters contend continuously: 0,1,0,1
    rst = 1'b1;
    #1;
    rst = 1'b0;
    r0v = 1'b1; r0d = 64'h4000_0000_0000_0000; r0t = 4'd5;
    r1v = 1'b1; r1d = 64'hC01C_0000_0000_0000; r1t = 4'd9;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) run_txn(1'b0, 4'd5, 64'h4000_0000_0000_0000, 64'd2, 1'b0);
      else            run_txn(1'b1, 4'd9, 64'hC01C_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
    end
    r0v = 1'b0; r1v = 1'b0;

    // Backpressure: resp_ready low for 5 RESP cycles while req1 waits
    rr = 1'b0;
    r0v = 1'b1; r0d = 64'h4024_0000_0000_0000; r0t = 4'd1;
    #1;
    check("bp_grant0", {63'd0, req0_ready}, 64'd1);
    step;
    r0v = 1'b0;
    r1v = 1'b1; r1d = 64'hC01C_0000_0000_0000; r1t = 4'd6;
    step;
    for (int k = 0; k < 5; k++) begin
      check("bp_vld", {63'd0, resp_valid}, 64'd1);
      check("bp_data", resp_data, 64'd10);
      check("bp_tag", {60'd0, resp_tag}, 64'd1);
      check("bp_rdy1", {63'd0, req1_ready}, 64'd0);
      step;
    end
    rr = 1'b1;
    step;
    run_txn(1'b1, 4'd6, 64'hC01C_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
    r1v = 1'b0;

    // NaN and -inf flag invalid and saturate
    r0v = 1'b1; r0d = 64'h7FF8_0000_0000_0000; r0t = 4'd2;
    run_txn(1'b0, 4'd2, 64'h7FF8_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    r0d = 64'hFFF0_0000_0000_0000; r0t = 4'd8;
    run_txn(1'b0, 4'd8, 64'hFFF0_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
    r0v = 1'b0;

    // Reset in EXEC abandons the operation without a clock edge
    r0v = 1'b1; r0d = 64'h4000_0000_0000_0000; r0t = 4'd7;
    #1;
    check("ex_grant0", {63'd0, req0_ready}, 64'd1);
    step;
    r0v = 1'b0;
    check("ex_cvt_in", cvt_in, 64'h4000_0000_0000_0000);
    rst = 1'b1;
    #1;
    check("ex_rst_vld", {63'd0, resp_valid}, 64'd0);
    check("ex_rst_data", resp_data, 64'd0);
    check("ex_rst_nv", {63'd0, resp_nv}, 64'd0);
    check("ex_rst_tag", {60'd0, resp_tag}, 64'd0);
    check("ex_rst_cvt_in", cvt_in, 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step;
      check("ex_no_resp", {63'd0, resp_valid}, 64'd0);
    end
    r1v = 1'b1; r1d = 64'h4024_0000_0000_0000; r1t = 4'd2;
    run_txn(1'b1, 4'd2, 64'h4024_0000_0000_0000, 64'd10, 1'b0);
    r1v = 1'b0;

    // Single precision: -3.14159 truncates to -3, then a quiet NaN
    s_r0v = 1'b1; s_r0d = 32'hC049_0FDB; s_r0t = 4'd4;
    #1;
    check("s_grant0", {63'd0, s_req0_ready}, 64'd1);
    step; step;
    check("s_vld", {63'd0, s_resp_valid}, 64'd1);
    check("s_data", {32'd0, s_resp_data}, {32'd0, 32'hFFFF_FFFD});
    check("s_nv", {63'd0, s_resp_nv}, 64'd0);
    check("s_tag", {60'd0, s_resp_tag}, 64'd4);
    s_r0d = 32'h7FC0_0000; s_r0t = 4'd5;
    step; step; step;
    check("s_nan_data", {32'd0, s_resp_data}, {32'd0, 32'h7FFF_FFFF});
    check("s_nan_nv", {63'd0, s_resp_nv}, 64'd1);
    s_r0v = 1'b0;
    step;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
